l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
- Shares the single next-level (L2) line-fill port between the instruction cache and the data cache.
- Each L1 cache emits a 26-bit line address (address bits 31:6) on a miss or write-through; this block buffers each stream in a small FIFO.
- It round-robin arbitrates between the two streams and drives one registered valid/ready request to L2.
- It keeps grant and stall counters for the statistics module.

Parameters:
ADDR_W, 26, line address width (address bits 31:6)
DEPTH, 4, entries per requester FIFO; power of two, minimum 2
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ic_req_valid  input  1  I-cache has a line address to send
ic_req_addr  input  ADDR_W  I-cache line address
ic_req_ready  output  1  I-cache FIFO can accept
dc_req_valid  input  1  D-cache has a line address to send
dc_req_addr  input  ADDR_W  D-cache line address
dc_req_ready  output  1  D-cache FIFO can accept
l2_valid  output  1  request presented to L2
l2_addr  output  ADDR_W  line address to L2
l2_src  output  1  0 = I-cache, 1 = D-cache
l2_ready  input  1  L2 accepts the request this cycle
clear_stats  input  1  synchronous clear of the counters only
ic_grants  output  CNT_W  count of I-cache requests accepted by L2
dc_grants  output  CNT_W  count of D-cache requests accepted by L2
stall_cycles  output  CNT_W  cycles with l2_valid=1 and l2_ready=0, saturating

Behaviour:
- Reset (async, rst=1):
  - Both FIFOs empty; pointers and occupancy = 0.
  - l2_valid=0, l2_addr=0, l2_src=0.
  - All counters = 0.
  - last_src=1, so the I-cache wins the first tie.
  - Entries pending at reset are dropped; reset mid-handshake is legal.
- Push:
  - x_req_ready = !full_x, driven combinationally from occupancy.
  - An entry is written when x_req_valid & x_req_ready.
  - No bypass: a full FIFO stays not-ready in a cycle where it is also popped.
  - ready rises one cycle after the pop.
- Output slot FSM, two states:
  - IDLE (l2_valid=0): if either FIFO is non-empty, load the winner into the output register at the edge and go to HOLD.
  - HOLD (l2_valid=1): l2_addr and l2_src are held stable until l2_valid & l2_ready.
    - On the accepting edge, if a FIFO is non-empty, reload immediately and stay in HOLD (back-to-back, one request per cycle).
    - Otherwise go to IDLE.
- Arbitration, evaluated whenever the slot is loaded:
  - Only one FIFO non-empty: pick it.
  - Both non-empty: pick !last_src.
  - last_src updates to the picked source on every load.
  - Neither source can be starved: with both streams backlogged, grants alternate strictly.
- Latency:
  - Push accepted at edge N into an empty FIFO, slot IDLE: l2_valid=1 in the cycle after edge N+1.
  - FIFO order is preserved per source.
  - A push and a pop on the same FIFO in the same cycle leave occupancy unchanged.
- Counters:
  - On handshake, increment ic_grants or dc_grants according to l2_src.
  - stall_cycles increments each cycle with l2_valid & !l2_ready.
  - All counters saturate at all-ones, no wrap.
  - clear_stats zeroes all counters synchronously, with priority over a same-cycle increment. It does not touch FIFOs or the slot.
- Width rules:
  - Occupancy counters are log2(DEPTH)+1 bits.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally at DEPTH.

Test Plan:
1. Reset mid-operation: fill both FIFOs, hold l2_ready=0, assert rst -> l2_valid=0 immediately; both ready=1 after rst drops; counters=0; next request is the first one pushed after reset.
2. Single stream: I-cache pushes 0x0000001, 0x0000002, 0x0000003 with l2_ready=1 -> l2_addr sequence 1,2,3, l2_src=0, first l2_valid two edges after the first push, ic_grants=3, dc_grants=0.
3. Contention: both FIFOs preloaded with 4 entries each (I: 0x10..0x13, D: 0x20..0x23), l2_ready=1 -> order 0x10,0x20,0x11,0x21,... with l2_src alternating 0,1,0,1; one grant per cycle; final counts 4/4.
4. Backpressure and full: l2_ready=0 for 10 cycles while the D-cache pushes 6 entries -> dc_req_ready=0 after DEPTH entries plus the one in the output slot; l2_addr stable; stall_cycles=10; no entry lost or duplicated after l2_ready=1.
5. Full FIFO pushed and popped in the same cycle -> push not accepted, occupancy drops by 1, ready=1 the next cycle.
6. Counters: preload ic_grants to all-ones, then another I-cache grant -> value stays all-ones; clear_stats asserted together with a grant -> counter reads 0 on the next cycle.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares the single L2 line-fill port between the I-cache and
// the D-cache. Each requester has its own small FIFO of line addresses. A
// round-robin arbiter loads one entry at a time into a registered valid/ready
// output slot. Saturating grant and stall counters feed the statistics block.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   ic_req_valid/addr/ready         I-cache push interface (ready = FIFO not full)
//   dc_req_valid/addr/ready         D-cache push interface (ready = FIFO not full)
//   l2_valid/addr/src, l2_ready     registered request to L2 (src: 0=I, 1=D)
//   clear_stats                     synchronous clear of the counters only
//   ic_grants, dc_grants            accepted requests per source, saturating
//   stall_cycles                    cycles with l2_valid & !l2_ready, saturating
module l2_req_arbiter #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  output logic              l2_valid,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_src,
  input  logic              l2_ready,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  ic_grants,
  output logic [CNT_W-1:0]  dc_grants,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  // Index 0 is the I-cache stream, index 1 the D-cache stream.
  logic [ADDR_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [PTR_W:0]    count [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [1:0]        in_valid;
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        push;
  logic [1:0]        pop;

  state_t state;
  logic   last_src;
  logic   load;
  logic   pick;

  always_comb begin
    in_addr[0] = ic_req_addr;
    in_addr[1] = dc_req_addr;
    in_valid   = {dc_req_valid, ic_req_valid};
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]  = (count[i] == FULL_CNT);
      empty[i] = (count[i] == '0);
    end
    // Ready depends only on registered occupancy, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    push = in_valid & ~full;
  end

  assign ic_req_ready = ~full[0];
  assign dc_req_ready = ~full[1];

  // The slot takes a new entry when it is empty or its current request is
  // being accepted this cycle, giving one request per cycle when backlogged.
  always_comb begin
    load = (~&empty) && ((state == IDLE) || l2_ready);
    if (!empty[0] && !empty[1])
      pick = ~last_src;
    else
      pick = empty[0];
    pop = '0;
    if (load)
      pop[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= in_addr[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])
          count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i])
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      l2_valid <= 1'b0;
      l2_addr  <= '0;
      l2_src   <= 1'b0;
      last_src <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state    <= HOLD;
            l2_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (l2_ready && !load) begin
            state    <= IDLE;
            l2_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          l2_valid <= 1'b0;
        end
      endcase
      if (load) begin
        l2_addr  <= mem[pick][rd_ptr[pick]];
        l2_src   <= pick;
        last_src <= pick;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_grants    <= '0;
      dc_grants    <= '0;
      stall_cycles <= '0;
    end else if (clear_stats) begin
      ic_grants    <= '0;
      dc_grants    <= '0;
      stall_cycles <= '0;
    end else begin
      if (l2_valid && l2_ready && !l2_src && ic_grants != '1)
        ic_grants <= ic_grants + 1'b1;
      if (l2_valid && l2_ready && l2_src && dc_grants != '1)
        dc_grants <= dc_grants + 1'b1;
      if (l2_valid && !l2_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: tasks push expected {src, addr} entries
// as stimulus is driven; the handshake monitor pops and compares them.
module tb_l2_req_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_req_valid = 1'b0;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_req_ready;
  logic          dc_req_valid = 1'b0;
  logic [AW-1:0] dc_req_addr = '0;
  logic          dc_req_ready;
  logic          l2_valid;
  logic [AW-1:0] l2_addr;
  logic          l2_src;
  logic          l2_ready = 1'b0;
  logic          clear_stats = 1'b0;
  logic [CW-1:0] ic_grants;
  logic [CW-1:0] dc_grants;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int passed = 0;
  logic [AW:0] exp_q [$];
  logic [AW:0] mon_exp;

  l2_req_arbiter #(.ADDR_W(AW), .DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
    .l2_valid(l2_valid), .l2_addr(l2_addr), .l2_src(l2_src), .l2_ready(l2_ready),
    .clear_stats(clear_stats),
    .ic_grants(ic_grants), .dc_grants(dc_grants), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  // Handshake monitor: every accepted request must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && l2_valid && l2_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL handshake_unexpected: got src=%0d addr=%h, required no request",
                 l2_src, l2_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({l2_src, l2_addr} !== mon_exp)
          $display("FAIL handshake: got src=%0d addr=%h, required src=%0d addr=%h",
                   l2_src, l2_addr, mon_exp[AW], mon_exp[AW-1:0]);
        else
          passed++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({l2_valid, l2_src, l2_addr} !== '0)
      $display("FAIL reset_slot: got valid=%0d src=%0d addr=%h, required 0/0/0", l2_valid, l2_src, l2_addr);
    else passed++;
    checks++;
    if ({ic_req_ready, dc_req_ready} !== 2'b11 || {ic_grants, dc_grants, stall_cycles} !== '0)
      $display("FAIL reset_state: got rdy=%b cnt=%h/%h/%h, required rdy=11 cnt=0",
               {ic_req_ready, dc_req_ready}, ic_grants, dc_grants, stall_cycles);
    else passed++;
    // Fill both FIFOs with L2 stalled; these entries must be dropped by reset.
    cyc();
    l2_ready = 1'b0;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ic_req_addr = 26'(32'hA0 + i);
      dc_req_addr = 26'(32'hB0 + i);
      cyc();
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ic_req_ready, dc_req_ready, l2_valid} !== 3'b001 || stall_cycles !== 4'd4)
      $display("FAIL prefill: got rdy=%b valid=%0d stall=%0d, required rdy=00 valid=1 stall=4",
               {ic_req_ready, dc_req_ready}, l2_valid, stall_cycles);
    else passed++;
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (l2_valid !== 1'b0 || stall_cycles !== '0)
      $display("FAIL reset_async: got valid=%0d stall=%0d, required 0/0", l2_valid, stall_cycles);
    else passed++;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ic_req_ready, dc_req_ready, l2_valid} !== 3'b110)
      $display("FAIL reset_release: got rdy=%b valid=%0d, required rdy=11 valid=0",
               {ic_req_ready, dc_req_ready}, l2_valid);
    else passed++;
    cyc();
    l2_ready = 1'b1;
    dc_req_valid = 1'b1;
    dc_req_addr = 26'h3AB;
    exp_q.push_back({1'b1, 26'h3AB});
    cyc();
    dc_req_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || dc_grants !== 4'd1 || ic_grants !== 4'd0)
      $display("FAIL reset_first_req: got pending=%0d grants=%0d/%0d, required 0 and 0/1",
               exp_q.size(), ic_grants, dc_grants);
    else passed++;
    cyc();
  endtask

  task automatic test_single_stream();
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    l2_ready = 1'b1;
    ic_req_valid = 1'b1;
    ic_req_addr = 26'h1;
    exp_q.push_back({1'b0, 26'h1});
    cyc();
    ic_req_addr = 26'h2;
    exp_q.push_back({1'b0, 26'h2});
    @(negedge clk);
    checks++;
    if (l2_valid !== 1'b0)
      $display("FAIL latency_early: got valid=%0d, required 0", l2_valid);
    else passed++;
    cyc();
    ic_req_addr = 26'h3;
    exp_q.push_back({1'b0, 26'h3});
    @(negedge clk);
    checks++;
    if ({l2_valid, l2_src, l2_addr} !== {1'b1, 1'b0, 26'h1})
      $display("FAIL latency_first: got valid=%0d src=%0d addr=%h, required 1/0/1", l2_valid, l2_src, l2_addr);
    else passed++;
    cyc();
    ic_req_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || ic_grants !== 4'd3 || dc_grants !== 4'd0)
      $display("FAIL single_counts: got pending=%0d grants=%0d/%0d, required 0 and 3/0",
               exp_q.size(), ic_grants, dc_grants);
    else passed++;
    cyc();
  endtask

  task automatic test_contention();
    int hs;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    l2_ready = 1'b0;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ic_req_addr = 26'(32'h10 + i);
      dc_req_addr = 26'(32'h20 + i);
      exp_q.push_back({1'b0, 26'(32'h10 + i)});
      exp_q.push_back({1'b1, 26'(32'h20 + i)});
      cyc();
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({l2_valid, l2_src, l2_addr} !== {1'b1, 1'b0, 26'h10} || dc_req_ready !== 1'b0)
      $display("FAIL contention_preload: got valid=%0d src=%0d addr=%h dc_rdy=%0d, required 1/0/10 dc_rdy=0",
               l2_valid, l2_src, l2_addr, dc_req_ready);
    else passed++;
    cyc();
    l2_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (l2_valid && l2_ready) hs++;
      cyc();
    end
    @(negedge clk);
    checks++;
    if (hs !== 8 || l2_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL contention_rate: got grants_in_8=%0d valid=%0d pending=%0d, required 8/0/0",
               hs, l2_valid, exp_q.size());
    else passed++;
    checks++;
    if (ic_grants !== 4'd4 || dc_grants !== 4'd4)
      $display("FAIL contention_counts: got %0d/%0d, required 4/4", ic_grants, dc_grants);
    else passed++;
    cyc();
  endtask

  task automatic test_backpressure();
    int idx;
    int stalls;
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    l2_ready = 1'b0;
    idx = 0;
    stalls = 0;
    dc_req_valid = 1'b1;
    dc_req_addr = 26'h40;
    for (int c = 0; c < 60 && (idx < 6 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (l2_valid && !l2_ready) begin
        stalls++;
        checks++;
        if (l2_addr !== 26'h40)
          $display("FAIL stall_stable: got addr=%h, required 40", l2_addr);
        else passed++;
        if (stalls == 10) begin
          checks++;
          if (dc_req_ready !== 1'b0 || idx !== 5)
            $display("FAIL full_accepted: got dc_rdy=%0d accepted=%0d, required 0/5", dc_req_ready, idx);
          else passed++;
        end
      end
      if (dc_req_valid && dc_req_ready) begin
        exp_q.push_back({1'b1, 26'(32'h40 + idx)});
        idx++;
      end
      cyc();
      if (stalls >= 10) l2_ready = 1'b1;
      dc_req_valid = (idx < 6);
      dc_req_addr = 26'(32'h40 + idx);
    end
    dc_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || stall_cycles !== 4'd10 || dc_grants !== 4'd6)
      $display("FAIL backpressure_counts: got pending=%0d stall=%0d dc=%0d, required 0/10/6",
               exp_q.size(), stall_cycles, dc_grants);
    else passed++;
    cyc();
  endtask

  task automatic test_full_push_pop();
    int idx;
    logic full_seen;
    idx = 0;
    full_seen = 1'b0;
    l2_ready = 1'b0;
    ic_req_valid = 1'b1;
    ic_req_addr = 26'h50;
    for (int c = 0; c < 20 && !full_seen; c++) begin
      @(negedge clk);
      if (ic_req_ready) begin
        exp_q.push_back({1'b0, 26'(32'h50 + idx)});
        idx++;
        cyc();
        ic_req_addr = 26'(32'h50 + idx);
      end else begin
        full_seen = 1'b1;
      end
    end
    checks++;
    if (idx !== 5)
      $display("FAIL fill_count: got %0d accepted, required 5", idx);
    else passed++;
    cyc();
    l2_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b0)
      $display("FAIL full_pop_no_bypass: got ic_rdy=%0d, required 0", ic_req_ready);
    else passed++;
    cyc();
    l2_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b1)
      $display("FAIL ready_after_pop: got ic_rdy=%0d, required 1", ic_req_ready);
    else passed++;
    exp_q.push_back({1'b0, 26'h55});
    cyc();
    ic_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_ready !== 1'b0)
      $display("FAIL refull: got ic_rdy=%0d, required 0", ic_req_ready);
    else passed++;
    cyc();
    l2_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || l2_valid !== 1'b0)
      $display("FAIL full_drain: got pending=%0d valid=%0d, required 0/0", exp_q.size(), l2_valid);
    else passed++;
    cyc();
  endtask

  task automatic test_counters();
    int idx;
    int n;
    int st;
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    l2_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 15 : 1;
      idx = 0;
      ic_req_valid = 1'b1;
      ic_req_addr = 26'(32'h100 + 16 * r);
      for (int c = 0; c < 60 && (idx < n || exp_q.size() != 0); c++) begin
        @(negedge clk);
        if (ic_req_valid && ic_req_ready) begin
          exp_q.push_back({1'b0, 26'(32'h100 + 16 * r + idx)});
          idx++;
        end
        cyc();
        ic_req_valid = (idx < n);
        ic_req_addr = 26'(32'h100 + 16 * r + idx);
      end
      ic_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (ic_grants !== 4'hF || exp_q.size() != 0)
        $display("FAIL grant_saturate_r%0d: got ic=%0d pending=%0d, required 15/0", r, ic_grants, exp_q.size());
      else passed++;
      cyc();
    end
    l2_ready = 1'b0;
    ic_req_valid = 1'b1;
    ic_req_addr = 26'h1FF;
    exp_q.push_back({1'b0, 26'h1FF});
    cyc();
    ic_req_valid = 1'b0;
    st = 0;
    for (int c = 0; c < 40 && st < 17; c++) begin
      @(negedge clk);
      if (l2_valid && !l2_ready) st++;
      cyc();
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'hF)
      $display("FAIL stall_saturate: got %0d, required 15", stall_cycles);
    else passed++;
    cyc();
    l2_ready = 1'b1;
    clear_stats = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_valid !== 1'b1)
      $display("FAIL clear_grant_valid: got valid=%0d, required 1", l2_valid);
    else passed++;
    cyc();
    clear_stats = 1'b0;
    l2_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({ic_grants, dc_grants, stall_cycles} !== '0 || exp_q.size() != 0)
      $display("FAIL clear_priority: got %0d/%0d/%0d pending=%0d, required 0/0/0 pending=0",
               ic_grants, dc_grants, stall_cycles, exp_q.size());
    else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_full_push_pop();
    test_counters();
    repeat (3) cyc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
